// File: rtl/alu_result_bcd.sv
// rtl/alu_result_bcd.sv - ALU result to packed BCD converter (iterative double dabble)
module alu_result_bcd #(
    parameter int IN_W   = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       result,
    input  logic                  sign,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Digits needed for 2**IN_W-1: floor(IN_W*log10(2))+1.
    localparam int NAT_DIGITS = (IN_W * 30103) / 100000 + 1;
    localparam int ACC_DIGITS = (NAT_DIGITS > DIGITS) ? NAT_DIGITS : DIGITS;
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int CNT_W      = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IN_W-1:0]   mag;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_adj;
    logic [CNT_W-1:0]  iter;
    logic              neg_cap;
    logic              neg_in;
    logic              last_iter;
    logic              hi_nz;

    assign neg_in    = sign && result[IN_W-1];
    assign last_iter = (iter == CNT_W'(IN_W));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    generate
        if (ACC_DIGITS > DIGITS) begin : g_hi
            assign hi_nz = |acc[ACC_W-1:4*DIGITS];
        end else begin : g_no_hi
            assign hi_nz = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CONV;
            CONV:    if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < ACC_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    // The extra CONV cycle with iter==IN_W publishes the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag     <= '0;
            acc     <= '0;
            iter    <= '0;
            neg_cap <= 1'b0;
            bcd     <= '0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag     <= neg_in ? (~result + 1'b1) : result;
                        neg_cap <= neg_in;
                        acc     <= '0;
                        iter    <= '0;
                    end
                end
                CONV: begin
                    if (!last_iter) begin
                        acc  <= {acc_adj[ACC_W-2:0], mag[IN_W-1]};
                        mag  <= {mag[IN_W-2:0], 1'b0};
                        iter <= iter + 1'b1;
                    end else begin
                        bcd <= acc[4*DIGITS-1:0];
                        ovf <= hi_nz;
                        neg <= neg_cap;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_bcd.sv
// tb/tb_alu_result_bcd.sv - directed self-checking bench for alu_result_bcd
module tb_alu_result_bcd;

    logic        clk;
    logic        rst_n;
    logic [19:0] result;
    logic        sign;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] bcd;
    logic        neg;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int errors;

    alu_result_bcd #(.IN_W(20), .DIGITS(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .result    (result),
        .sign      (sign),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .neg       (neg),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] b;
        int t;
        t = v;
        b = '0;
        for (int i = 0; i < 6; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic wait_out_valid(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_conv(input logic s, input logic [19:0] r, input logic [23:0] eb,
                            input logic en, input logic eo, input int stall, input string tag);
        int n;
        logic [23:0] held;
        n = 0;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        sign     = s;
        result   = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_out_valid(tag, n);
        check({tag, "_lat"}, 32'(n), 32'd21);
        check({tag, "_bcd"}, 32'(bcd), 32'(eb));
        check({tag, "_neg"}, 32'(neg), 32'(en));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        held = bcd;
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_stall"}, 32'({out_valid, bcd}), 32'({1'b1, held}));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int v;
        logic [19:0] r;
        logic s;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        result    = '0;
        sign      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_flags", 32'({neg, ovf}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_conv(1'b0, 20'd12345, 24'h012345, 1'b0, 1'b0, 0, "t1");
        run_conv(1'b1, 20'hFFFFF, 24'h000001, 1'b1, 1'b0, 0, "t2a");
        run_conv(1'b1, 20'h80000, 24'h524288, 1'b1, 1'b0, 0, "t2b");
        run_conv(1'b0, 20'hFFFFF, 24'h048575, 1'b0, 1'b1, 0, "t3a");
        run_conv(1'b0, 20'h80000, 24'h524288, 1'b0, 1'b0, 0, "t3b");
        run_conv(1'b1, 20'h7FFFF, 24'h524287, 1'b0, 1'b0, 2, "pos_max");
        run_conv(1'b1, 20'h00000, 24'h000000, 1'b0, 1'b0, 0, "zero");

        // Backpressure with a new request pending the whole time.
        sign     = 1'b0;
        result   = 20'd777;
        in_valid = 1'b1;
        tick();
        result   = 20'd111;
        wait_out_valid("bp", n);
        check("bp_bcd", 32'(bcd), 32'h000777);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold", 32'({out_valid, in_ready, bcd}), 32'({1'b1, 1'b0, 24'h000777}));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
        tick();
        in_valid = 1'b0;
        check("bp_accept", 32'(in_ready), 32'd0);
        wait_out_valid("bp2", n);
        check("bp2_bcd", 32'(bcd), 32'h000111);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a conversion.
        sign     = 1'b1;
        result   = 20'hFFFF0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_bcd", 32'(bcd), 32'd0);
        check("mid_rst_flags", 32'({neg, ovf}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        run_conv(1'b0, 20'd999999, 24'h999999, 1'b0, 1'b0, 0, "t5");

        // Short random sweep against an arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            r = 20'($urandom_range(0, 20'hFFFFF));
            s = 1'($urandom_range(0, 1));
            v = (s && r[19]) ? (1 << 20) - int'(r) : int'(r);
            run_conv(s, r, to_bcd(v % 1000000), s && r[19], v >= 1000000,
                     int'($urandom_range(0, 3)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
